// File: rtl/axi3_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 read port between N_MST burst readers.
// One burst in flight at a time; the owner keeps the port until its RLAST beat.
module axi3_rd_arbiter #(
  parameter int unsigned N_MST      = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MST-1:0]            m_arvalid,
  output logic [N_MST-1:0]            m_arready,
  input  logic [N_MST*ADDR_WIDTH-1:0] m_araddr,
  input  logic [N_MST*ID_WIDTH-1:0]   m_arid,
  input  logic [N_MST*4-1:0]          m_arlen,
  input  logic [N_MST*3-1:0]          m_arsize,
  input  logic [N_MST*2-1:0]          m_arburst,
  output logic [N_MST-1:0]            m_rvalid,
  input  logic [N_MST-1:0]            m_rready,
  output logic [DATA_WIDTH-1:0]       m_rdata,
  output logic [ID_WIDTH-1:0]         m_rid,
  output logic [1:0]                  m_rresp,
  output logic                        m_rlast,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  output logic [ADDR_WIDTH-1:0]       s_araddr,
  output logic [ID_WIDTH-1:0]         s_arid,
  output logic [3:0]                  s_arlen,
  output logic [2:0]                  s_arsize,
  output logic [1:0]                  s_arburst,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [DATA_WIDTH-1:0]       s_rdata,
  input  logic [ID_WIDTH-1:0]         s_rid,
  input  logic [1:0]                  s_rresp,
  input  logic                        s_rlast,
  output logic                        busy,
  output logic                        proto_err
);

  localparam int unsigned IdxW = (N_MST > 1) ? $clog2(N_MST) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [3:0]            beat_cnt_q, beat_cnt_d;
  logic                  proto_err_q, proto_err_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [3:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;

  logic [IdxW-1:0]       winner;
  logic                  win_found;
  logic [IdxW:0]         cand_sum;
  logic [IdxW-1:0]       cand;

  // First requester found scanning upward from rr_ptr, wrapping at N_MST.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_MST; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (cand_sum >= (IdxW+1)'(N_MST)) begin
        cand_sum = cand_sum - (IdxW+1)'(N_MST);
      end
      cand = cand_sum[IdxW-1:0];
      if (!win_found && m_arvalid[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = proto_err_q;
    araddr_d    = araddr_q;
    arid_d      = arid_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    m_arready   = '0;
    m_rvalid    = '0;
    s_rready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          // No grant is offered while reset is held low.
          m_arready[winner] = rst;
          araddr_d          = m_araddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
          arid_d            = m_arid[winner*ID_WIDTH +: ID_WIDTH];
          arlen_d           = m_arlen[winner*4 +: 4];
          arsize_d          = m_arsize[winner*3 +: 3];
          arburst_d         = m_arburst[winner*2 +: 2];
          grant_d           = winner;
          beat_cnt_d        = '0;
          state_d           = StAddr;
        end
      end
      StAddr: begin
        if (s_arready) begin
          state_d = StData;
        end
      end
      StData: begin
        m_rvalid[grant_q] = s_rvalid;
        s_rready          = m_rready[grant_q];
        if (s_rvalid && m_rready[grant_q]) begin
          beat_cnt_d = (beat_cnt_q == 4'd15) ? beat_cnt_q : beat_cnt_q + 4'd1;
          // Flag RLAST arriving early/late; only RLAST itself ends the burst.
          if (s_rlast != (beat_cnt_q == arlen_q)) begin
            proto_err_d = 1'b1;
          end
          if (s_rlast) begin
            state_d  = StIdle;
            rr_ptr_d = (grant_q == IdxW'(N_MST - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
      araddr_q    <= '0;
      arid_q      <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
      araddr_q    <= araddr_d;
      arid_q      <= arid_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
    end
  end

  assign s_arvalid = (state_q == StAddr);
  assign s_araddr  = araddr_q;
  assign s_arid    = arid_q;
  assign s_arlen   = arlen_q;
  assign s_arsize  = arsize_q;
  assign s_arburst = arburst_q;

  assign m_rdata   = s_rdata;
  assign m_rid     = s_rid;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;

  assign busy      = (state_q != StIdle);
  assign proto_err = proto_err_q;

endmodule
